config_frame_writer: RTL and testbench

//  Drives per-row config frame data and per-column frame strobes into tile configuration latches.

---
 rtl/config_frame_pkg.sv | 34 +++
 rtl/config_frame_hdr_decode.sv | 31 +++
 rtl/config_frame_writer.sv | 216 +++++++++++++++++++++
 tb/tb_config_frame_writer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_frame_pkg.sv
// -----------------------------------------------------------------------------
// config_frame_pkg
// Shared definitions for the config frame writer: the header sync word, the
// header field layout and the frame-writer state type.
//
// Header word layout:
//   [31:16] sync (must equal SYNC_WORD)
//   [15:8]  target column
//   [7:0]   frame index within the column
// -----------------------------------------------------------------------------
package config_frame_pkg;

  localparam int WORD_W = 32;

  localparam logic [15:0] SYNC_WORD = 16'hFAB0;

  localparam int SYNC_LSB = 16;
  localparam int SYNC_W   = 16;
  localparam int COL_LSB  = 8;
  localparam int COL_W    = 8;
  localparam int FRM_LSB  = 0;
  localparam int FRM_W    = 8;

  // CHK is only reachable when the trailer checksum is built in.
  typedef enum logic [2:0] {
    HDR    = 3'd0,
    DATA   = 3'd1,
    CHK    = 3'd2,
    SETUP  = 3'd3,
    STROBE = 3'd4,
    HOLD   = 3'd5
  } state_t;

endpackage

// File: rtl/config_frame_hdr_decode.sv
// -----------------------------------------------------------------------------
// config_frame_hdr_decode
// Purely combinational split of a frame header word into its fields, plus
// the sync and address range qualifiers.
//
// Ports:
//   s_data   in   32  candidate header word
//   sync_ok  out  1   sync field matches SYNC_WORD
//   col      out  8   column field
//   frame    out  8   frame index field
//   addr_ok  out  1   column < NumColumns and frame < MaxFramesPerCol
// -----------------------------------------------------------------------------
module config_frame_hdr_decode
  import config_frame_pkg::*;
#(
  parameter int NumColumns      = 16,
  parameter int MaxFramesPerCol = 20
) (
  input  logic [WORD_W-1:0] s_data,
  output logic              sync_ok,
  output logic [COL_W-1:0]  col,
  output logic [FRM_W-1:0]  frame,
  output logic              addr_ok
);

  assign sync_ok = (s_data[SYNC_LSB +: SYNC_W] == SYNC_WORD);
  assign col     = s_data[COL_LSB +: COL_W];
  assign frame   = s_data[FRM_LSB +: FRM_W];
  assign addr_ok = (int'(col) < NumColumns) && (int'(frame) < MaxFramesPerCol);

endmodule

// File: rtl/config_frame_writer.sv
// -----------------------------------------------------------------------------
// config_frame_writer
// Assembles configuration frames from a 32-bit valid/ready word stream and
// drives them into the fabric's tile configuration latches. Each frame is a
// header word followed by NumRows data words (one word per row); the frame is
// committed by a single-cycle strobe on the addressed column/frame line,
// preceded by a setup cycle and followed by a hold cycle.
//
// Build option:
//   FRAME_CHECKSUM_EN  when defined, one trailer word follows the data words;
//                      it must equal the XOR of the header and all data words,
//                      otherwise the strobe is suppressed and err is set.
//
// Ports:
//   CLK          in   1                            clock
//   RESET        in   1                            synchronous reset, active-high
//   s_data       in   32                           stream word (header/data/trailer)
//   s_valid      in   1                            s_data valid
//   s_ready      out  1                            word taken when s_valid && s_ready
//   FrameData    out  FrameBitsPerRow*NumRows      row r at [r*32 +: 32]
//   FrameStrobe  out  NumColumns*MaxFramesPerCol   col c, frame f at c*MaxFramesPerCol+f
//   frame_done   out  1                            one pulse per completed or dropped frame
//   err          out  1                            sticky: bad sync, bad address, bad checksum
//
// FrameBitsPerRow must be 32: each row is fed by exactly one stream word.
// -----------------------------------------------------------------------------
module config_frame_writer
  import config_frame_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows         = 16,
  parameter int NumColumns      = 16
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic [WORD_W-1:0]                     s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic [FrameBitsPerRow*NumRows-1:0]    FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  frame_done,
  output logic                                  err
);

  localparam int              RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);

  state_t                     state_q;
  state_t                     state_d;
  logic   [RowW-1:0]          row_q;
  logic   [COL_W-1:0]         col_q;
  logic   [FRM_W-1:0]         frm_q;
  logic                       drop_q;
  logic                       err_q;
  logic   [FrameBitsPerRow-1:0] rows_q [NumRows];
  logic                       strobe_en;

`ifdef FRAME_CHECKSUM_EN
  logic   [WORD_W-1:0]        csum_q;
`endif

  logic                       hdr_sync_ok;
  logic   [COL_W-1:0]         hdr_col;
  logic   [FRM_W-1:0]         hdr_frm;
  logic                       hdr_addr_ok;

  config_frame_hdr_decode #(
    .NumColumns      (NumColumns),
    .MaxFramesPerCol (MaxFramesPerCol)
  ) u_hdr_decode (
    .s_data  (s_data),
    .sync_ok (hdr_sync_ok),
    .col     (hdr_col),
    .frame   (hdr_frm),
    .addr_ok (hdr_addr_ok)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= HDR;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and control outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first; a path that leaves
  // one unassigned would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    frame_done = 1'b0;
    strobe_en  = 1'b0;
    unique case (state_q)
      HDR: begin
        s_ready = 1'b1;
        // A bad sync word is swallowed here; a bad address still walks the
        // whole frame so the data words are consumed and the stream stays
        // aligned, but drop_q keeps the strobe off.
        if (s_valid && hdr_sync_ok) state_d = DATA;
      end
      DATA: begin
        s_ready = 1'b1;
        if (s_valid && (row_q == LastRow)) begin
`ifdef FRAME_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = SETUP;
`endif
        end
      end
`ifdef FRAME_CHECKSUM_EN
      CHK: begin
        s_ready = 1'b1;
        if (s_valid) state_d = SETUP;
      end
`endif
      SETUP:  state_d = STROBE;
      STROBE: begin
        strobe_en = !drop_q;
        state_d   = HOLD;
      end
      HOLD: begin
        frame_done = 1'b1;
        state_d    = HDR;
      end
      default: state_d = HDR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: header latch, row counter, row registers, checksum, error flag
  // ---------------------------------------------------------------------------
  // NOTE: the row registers are reset together with the control state because
  // a reset must leave FrameData at zero, not at a partially loaded frame.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      row_q  <= '0;
      col_q  <= '0;
      frm_q  <= '0;
      drop_q <= 1'b0;
      err_q  <= 1'b0;
      for (int r = 0; r < NumRows; r++) rows_q[r] <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      unique case (state_q)
        HDR: begin
          if (s_valid) begin
            if (!hdr_sync_ok) begin
              err_q <= 1'b1;
            end else begin
              col_q  <= hdr_col;
              frm_q  <= hdr_frm;
              row_q  <= '0;
              drop_q <= !hdr_addr_ok;
              if (!hdr_addr_ok) err_q <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
              csum_q <= s_data;
`endif
            end
          end
        end
        DATA: begin
          if (s_valid) begin
            rows_q[row_q] <= s_data;
            row_q         <= row_q + 1'b1;
`ifdef FRAME_CHECKSUM_EN
            csum_q        <= csum_q ^ s_data;
`endif
          end
        end
`ifdef FRAME_CHECKSUM_EN
        CHK: begin
          if (s_valid && (s_data != csum_q)) begin
            drop_q <= 1'b1;
            err_q  <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign err = err_q;

  // ---------------------------------------------------------------------------
  // Row registers onto the flat FrameData bus
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < NumRows; r++) begin : g_row
    assign FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] = rows_q[r];
  end

  // ---------------------------------------------------------------------------
  // Strobe decoder: one-hot on the latched column/frame, only in STROBE.
  // drop_q is set whenever the latched address is out of range, so an
  // enabled strobe always lands on an existing line.
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NumColumns; c++) begin : g_col
    for (genvar f = 0; f < MaxFramesPerCol; f++) begin : g_frm
      assign FrameStrobe[c*MaxFramesPerCol + f] =
        strobe_en && (col_q == COL_W'(c)) && (frm_q == FRM_W'(f));
    end
  end

endmodule

// File: tb/tb_config_frame_writer.sv
// -----------------------------------------------------------------------------
// tb_config_frame_writer
// Directed bench for config_frame_writer. A word-level model tracks what the
// outputs must be from the frame rules (rows written, post-frame gap of three
// busy cycles with the strobe in the middle one and frame_done in the last)
// and is compared against the DUT on every cycle. Directed tests add literal
// expectations for specific strobe bits, row values and flags.
// Build with +define+FRAME_CHECKSUM_EN to exercise the trailer checksum.
// -----------------------------------------------------------------------------
module tb_config_frame_writer;

  localparam int NR = 16;
  localparam int NC = 16;
  localparam int NF = 20;

  logic              clk;
  logic              rst;
  logic [31:0]       s_data;
  logic              s_valid;
  logic              s_ready;
  logic [NR*32-1:0]  frame_data;
  logic [NC*NF-1:0]  frame_strobe;
  logic              frame_done;
  logic              err;

  int checks = 0;
  int errors = 0;

  config_frame_writer #(
    .FrameBitsPerRow (32),
    .MaxFramesPerCol (NF),
    .NumRows         (NR),
    .NumColumns      (NC)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .FrameData   (frame_data),
    .FrameStrobe (frame_strobe),
    .frame_done  (frame_done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Word-level model
  // ---------------------------------------------------------------------------
  logic [31:0] m_rows [NR];
  int          m_gap;       // busy cycles left after a frame's last word
  bit          m_in_frame;  // header taken, waiting for data/trailer
  int          m_words;
  int          m_col;
  int          m_frm;
  bit          m_drop;
  bit          m_err;
  bit          m_live = 1'b0;
  logic [31:0] m_csum;

  always @(posedge clk) begin
    if (rst) begin
      m_gap      = 0;
      m_in_frame = 0;
      m_words    = 0;
      m_drop     = 0;
      m_err      = 0;
      m_col      = 0;
      m_frm      = 0;
      m_csum     = '0;
      m_live     = 1'b1;
      for (int i = 0; i < NR; i++) m_rows[i] = '0;
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (s_valid) begin
      if (!m_in_frame) begin
        if (s_data[31:16] != 16'hFAB0) begin
          m_err = 1;
        end else begin
          m_in_frame = 1;
          m_words    = 0;
          m_col      = int'(s_data[15:8]);
          m_frm      = int'(s_data[7:0]);
          m_drop     = (m_col >= NC) || (m_frm >= NF);
          if (m_drop) m_err = 1;
          m_csum     = s_data;
        end
      end else if (m_words < NR) begin
        m_rows[m_words] = s_data;
        m_words++;
        m_csum = m_csum ^ s_data;
`ifndef FRAME_CHECKSUM_EN
        if (m_words == NR) begin
          m_in_frame = 0;
          m_gap      = 3;
        end
`endif
      end else begin
        if (s_data != m_csum) begin
          m_drop = 1;
          m_err  = 1;
        end
        m_in_frame = 0;
        m_gap      = 3;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare and event counters
  // ---------------------------------------------------------------------------
  int ready_low_cycles = 0;
  int strobe_cycles    = 0;
  int done_cycles      = 0;

  always @(negedge clk) begin
    logic [511:0]     exp_data;
    logic [NC*NF-1:0] exp_strobe;
    if (m_live) begin
      exp_data = '0;
      for (int r = 0; r < NR; r++) exp_data[r*32 +: 32] = m_rows[r];
      exp_strobe = '0;
      if (m_gap == 2 && !m_drop) exp_strobe[m_col*NF + m_frm] = 1'b1;
      check("cyc_ready",  {511'b0, s_ready},    {511'b0, (m_gap == 0)});
      check("cyc_data",   frame_data,           exp_data);
      check("cyc_strobe", {192'b0, frame_strobe}, {192'b0, exp_strobe});
      check("cyc_done",   {511'b0, frame_done}, {511'b0, (m_gap == 1)});
      check("cyc_err",    {511'b0, err},        {511'b0, m_err});
      if (s_ready === 1'b0) ready_low_cycles++;
      if (|frame_strobe)    strobe_cycles++;
      if (frame_done)       done_cycles++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all entered and left at a negedge)
  // ---------------------------------------------------------------------------
  task automatic send_word(input logic [31:0] w, input int max_idle);
    int n;
    if (max_idle > 0) begin
      int k;
      k = int'($urandom_range(max_idle));
      s_valid = 1'b0;
      repeat (k) @(negedge clk);
    end
    s_data  = w;
    s_valid = 1'b1;
    n = 0;
    while (m_gap != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (m_gap != 0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got busy expected ready within 50 cycles");
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] base,
                            input int max_idle, input bit corrupt);
    logic [31:0] x;
    logic [31:0] trailer;
    x = hdr;
    send_word(hdr, max_idle);
    for (int r = 0; r < NR; r++) begin
      send_word(base + 32'(r), max_idle);
      x = x ^ (base + 32'(r));
    end
    trailer = corrupt ? (x ^ 32'h1) : x;
`ifdef FRAME_CHECKSUM_EN
    send_word(trailer, max_idle);
`endif
  endtask

  // Called at the negedge right after the frame's final word was taken.
  // idx < 0 means the strobe must stay all-zero.
  task automatic finish_frame(input string name, input int idx);
    s_valid = 1'b0;
    check({name, "_setup_strobe"}, {192'b0, frame_strobe}, '0);
    check({name, "_setup_ready"},  {511'b0, s_ready}, 512'd0);
    @(negedge clk);
    if (idx >= 0) begin
      check({name, "_strobe_bit"}, {511'b0, frame_strobe[idx]}, 512'd1);
      check({name, "_strobe_ones"}, 512'($countones(frame_strobe)), 512'd1);
    end else begin
      check({name, "_strobe_zero"}, {192'b0, frame_strobe}, '0);
    end
    @(negedge clk);
    check({name, "_done"}, {511'b0, frame_done}, 512'd1);
    @(negedge clk);
    check({name, "_ready_back"}, {511'b0, s_ready}, 512'd1);
  endtask

  task automatic reset_dut();
    s_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int s0;
    int d0;
    int r0;
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready",  {511'b0, s_ready}, 512'd1);
    check("rst_data",   frame_data, '0);
    check("rst_strobe", {192'b0, frame_strobe}, '0);
    check("rst_done",   {511'b0, frame_done}, 512'd0);
    check("rst_err",    {511'b0, err}, 512'd0);

    // 1: column 3, frame 5 -> strobe bit 65
    send_frame(32'hFAB0_0305, 32'h1000_0000, 0, 1'b0);
    finish_frame("t1", 65);
    check("t1_row0",  {480'b0, frame_data[31:0]},    512'h1000_0000);
    check("t1_row15", {480'b0, frame_data[511:480]}, 512'h1000_000F);
    check("t1_err",   {511'b0, err}, 512'd0);

    // 2: bad sync dropped, following frame col 1 frame 2 -> bit 22
    send_word(32'hDEAD_0000, 0);
    s_valid = 1'b0;
    check("t2_err",   {511'b0, err}, 512'd1);
    check("t2_ready", {511'b0, s_ready}, 512'd1);
    check("t2_row0_kept", {480'b0, frame_data[31:0]}, 512'h1000_0000);
    send_frame(32'hFAB0_0102, 32'h2000_0000, 0, 1'b0);
    finish_frame("t2", 22);
    check("t2_row5", {480'b0, frame_data[191:160]}, 512'h2000_0005);

    // 3: column 16 out of range: words consumed, no strobe, done pulses
    reset_dut();
    s0 = strobe_cycles;
    d0 = done_cycles;
    send_frame(32'hFAB0_1000, 32'h3000_0000, 0, 1'b0);
    finish_frame("t3", -1);
    check("t3_no_strobe", 512'(strobe_cycles - s0), 512'd0);
    check("t3_one_done",  512'(done_cycles - d0),   512'd1);
    check("t3_err",       {511'b0, err}, 512'd1);
    check("t3_row15",     {480'b0, frame_data[511:480]}, 512'h3000_000F);

    // 4: random stalls, last column / last frame -> bit 319
    reset_dut();
    r0 = ready_low_cycles;
    send_frame(32'hFAB0_0F13, 32'hA500_0000, 2, 1'b0);
    finish_frame("t4", 319);
    check("t4_ready_low", 512'(ready_low_cycles - r0), 512'd3);
    check("t4_row7",      {480'b0, frame_data[255:224]}, 512'hA500_0007);
    check("t4_row15",     {480'b0, frame_data[511:480]}, 512'hA500_000F);
    check("t4_err",       {511'b0, err}, 512'd0);

    // 5: reset after 7 data words, then frame col 0 frame 0 -> bit 0
    s0 = strobe_cycles;
    send_word(32'hFAB0_0304, 0);
    for (int r = 0; r < 7; r++) send_word(32'h5000_0000 + 32'(r), 0);
    reset_dut();
    check("t5_data",   frame_data, '0);
    check("t5_strobe", {192'b0, frame_strobe}, '0);
    check("t5_ready",  {511'b0, s_ready}, 512'd1);
    repeat (3) @(negedge clk);
    check("t5_no_strobe", 512'(strobe_cycles - s0), 512'd0);
    send_frame(32'hFAB0_0000, 32'h6000_0000, 0, 1'b0);
    finish_frame("t5", 0);
    check("t5_row6", {480'b0, frame_data[223:192]}, 512'h6000_0006);

`ifdef FRAME_CHECKSUM_EN
    // 6: correct trailer strobes, corrupted trailer drops the frame
    reset_dut();
    send_frame(32'hFAB0_0207, 32'h7000_0000, 1, 1'b0);
    finish_frame("t6_good", 47);
    check("t6_good_err", {511'b0, err}, 512'd0);
    d0 = done_cycles;
    send_frame(32'hFAB0_0207, 32'h8000_0000, 0, 1'b1);
    finish_frame("t6_bad", -1);
    check("t6_bad_err",  {511'b0, err}, 512'd1);
    check("t6_bad_done", 512'(done_cycles - d0), 512'd1);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
